line_burst_responder: RTL
=========================

// Module: line_burst_responder
// PURPOSE
//  Memory-side responder for the 128-bit cache-line interface that the L1/L2 caches initiate.
//  Accepts one line read or line write at a time and serializes it into 8 word beats on a 16-bit word memory port.
//  For reads, reassembles the beats into lc3b_l1_line/lc3b_l2_line layout, then answers the cache with a one-cycle line_resp.
//  Sits between the L2 cache miss path and physical memory.
// PARAMETERS
//  BEATS   8   words per line; must be a power of two; LINE_W = BEATS*WORD_W
//  WORD_W  16  memory word width; matches lc3b_word
// PORTS
//  clk          in   1    single clock; all state updates on posedge
//  reset_n      in   1    asynchronous, active-low reset
//  line_read    in   1    cache line-read request; held high until line_resp
//  line_write   in   1    cache line-write request; held high until line_resp
//  line_addr    in   16   byte address; bits [3:0] select the word/byte within the line
//  line_wdata   in   128  write line; word k = bits [16k+15:16k]; held stable while request is high
//  line_rdata   out  128  assembled read line; valid in the line_resp cycle
//  line_resp    out  1    one-cycle completion pulse
//  word_read    out  1    memory word read strobe
//  word_write   out  1    memory word write strobe
//  word_addr    out  16   {line_addr[15:4], beat, 1'b0}
//  word_wdata   out  16   current write beat
//  word_wmask   out  2    always 2'b11 during writes, 2'b00 otherwise
//  word_rdata   in   16   read beat data; valid with word_resp
//  word_resp    in   1    beat complete; memory asserts it >=1 cycle after the strobe
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, beat 0, line_rdata 0.
//  FSM states: IDLE, RD_BEAT, WR_BEAT, RESP.
//   IDLE:
//    - line_write -> WR_BEAT; if line_read and line_write are both high, write wins.
//    - otherwise line_read -> RD_BEAT.
//    - Latch the line address base and start beat. Strobes rise on the next cycle (registered outputs).
//   RD_BEAT:
//    - word_read held high; word_addr follows the current beat.
//    - On word_resp: word_rdata -> slot[beat]; beat <- beat+1 mod BEATS; count++.
//    - After the BEATS-th resp -> RESP.
//   WR_BEAT: same sequencing with word_write; word_wdata = line_wdata slot[beat].
//   RESP:
//    - line_resp = 1 for exactly one cycle, then -> IDLE.
//    - Strobes are low in RESP.
//    - IDLE ignores requests in the cycle right after RESP, so the initiator can drop its request.
//  Strobes stay high across consecutive beats. Only word_addr/word_wdata change, on the cycle after word_resp.
//  Latency: 1 + sum(beat latencies) + 1 cycles from request to line_resp. Minimum 1+8*1+1 = 10 cycles.
//  line_rdata holds its value until the next read completes; writes do not modify it.
//  word_resp outside RD_BEAT/WR_BEAT is ignored.
//  Request dropped mid-burst is an initiator protocol violation. The burst still completes and responds.
//  reset_n low mid-burst: immediate abort, outputs to reset values, no line_resp.
//  Beat counter is a 3-bit unsigned counter; wrap 7->0 is legal only under CRITICAL_WORD_FIRST_EN.
// CONFIGURATION
//  Macro CRITICAL_WORD_FIRST_EN:
//   - Defined: reads start at beat line_addr[3:1] and wrap modulo BEATS, e.g. 5,6,7,0,1,2,3,4.
//     Each beat's data lands in its true slot. Writes always start at beat 0.
//   - Undefined: all bursts start at beat 0 and run 0..7; line_addr[3:0] is ignored.
// STRUCTURE
//  Add to lc3b_types:
//   - typedef enum {brs_idle, brs_rd_beat, brs_wr_beat, brs_resp} lc3b_burst_state
//   - typedef logic [2:0] lc3b_beat
//   - localparam LC3B_LINE_BEATS = 8
//  Line data uses the existing lc3b_l2_line type.
//  One sub-module: burst_beat_counter.
//   - Inputs: load, start, inc. Outputs: beat, last.
//   - Holds a wrapping beat index plus a separate 3-bit issued-count.
//   - last asserts when the count equals BEATS-1 at an inc.
// TESTING
//  1 Read line_addr=16'h1230, memory word[a]=a^16'hA5A5, 1-cycle resp:
//    -> word_addr 1230,1232..123E; line_rdata slot k = (16'h1230+2k)^16'hA5A5.
//    -> line_resp at cycle 10 and lasts 1 cycle.
//  2 Write line_addr=16'h0040, line_wdata={8 words 16'h0007..16'h0000}:
//    -> 8 writes, word k = k at 0040+2k, wmask 11 -> single line_resp.
//  3 Random 1-5 cycle word_resp latency on reads:
//    -> strobe stays high continuously; data identical to test 1.
//  4 line_read and line_write asserted together:
//    -> write burst only; no word_read ever asserted.
//  5 reset_n low after 3rd read beat:
//    -> all outputs 0 asynchronously; no line_resp.
//    -> a following read completes normally from beat 0.
//  6 With CRITICAL_WORD_FIRST_EN, read line_addr=16'h123A:
//    -> beat order 5,6,7,0..4 (addr 123A..123E,1230..1238); line_rdata matches test 1.

Source files
------------

// File: rtl/line_burst_responder_pkg.sv
// ============================================================================
// Module      : line_burst_responder_pkg
// Description : Shared types for the cache-line burst responder: line/word
//               types, beat index type and burst FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package line_burst_responder_pkg;

    localparam int LC3B_LINE_BEATS = 8;
    localparam int LC3B_WORD_W     = 16;

    typedef logic [LC3B_WORD_W-1:0]                 lc3b_word;
    typedef logic [LC3B_LINE_BEATS*LC3B_WORD_W-1:0] lc3b_l2_line;
    typedef logic [2:0]                             lc3b_beat;

    // Burst FSM state encoding
    typedef logic [1:0] lc3b_burst_state;
    localparam lc3b_burst_state BRS_IDLE    = 2'd0;
    localparam lc3b_burst_state BRS_RD_BEAT = 2'd1;
    localparam lc3b_burst_state BRS_WR_BEAT = 2'd2;
    localparam lc3b_burst_state BRS_RESP    = 2'd3;

endpackage : line_burst_responder_pkg

`default_nettype wire

// File: rtl/line_burst_responder_beat_counter.sv
// ============================================================================
// Module      : burst_beat_counter
// Description : Wrapping beat index plus a separate issued-beat count.
//               'last' flags the increment that completes the final beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_beat_counter #(
    parameter int BEATS  = 8,
    parameter int BEAT_W = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [BEAT_W-1:0] start,
    input  logic              inc,
    output logic [BEAT_W-1:0] beat,
    output logic              last
);

    logic [BEAT_W-1:0] r_beat;
    logic [BEAT_W-1:0] r_count;

    assign beat = r_beat;
    assign last = inc && (r_count == BEAT_W'(BEATS - 1));

    // Load the start beat at burst start; advance index and count per completed beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat  <= '0;
            r_count <= '0;
        end else if (load) begin
            r_beat  <= start;
            r_count <= '0;
        end else if (inc && !last) begin
            r_beat  <= r_beat + 1'b1;
            r_count <= r_count + 1'b1;
        end
    end

endmodule : burst_beat_counter

`default_nettype wire

// File: rtl/line_burst_responder.sv
// ============================================================================
// Module      : line_burst_responder
// Description : Memory-side responder for 128-bit cache-line reads/writes.
//               Serializes each line into BEATS word beats on a 16-bit word
//               memory port and reassembles read beats into a line.
//               Optional macro CRITICAL_WORD_FIRST_EN: reads start at the
//               beat addressed by line_addr and wrap around the line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_burst_responder
    import line_burst_responder_pkg::*;
#(
    parameter int BEATS  = LC3B_LINE_BEATS,
    parameter int WORD_W = LC3B_WORD_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    line_read,
    input  logic                    line_write,
    input  logic [15:0]             line_addr,
    input  logic [BEATS*WORD_W-1:0] line_wdata,
    output logic [BEATS*WORD_W-1:0] line_rdata,
    output logic                    line_resp,
    output logic                    word_read,
    output logic                    word_write,
    output logic [15:0]             word_addr,
    output logic [WORD_W-1:0]       word_wdata,
    output logic [1:0]              word_wmask,
    input  logic [WORD_W-1:0]       word_rdata,
    input  logic                    word_resp
);

    localparam int LINE_W   = BEATS * WORD_W;
    localparam int BEAT_W   = $clog2(BEATS);
    localparam int ADDR_LSB = BEAT_W + 1;

    lc3b_burst_state       r_state;
    lc3b_burst_state       w_next_state;
    logic [15-ADDR_LSB:0]  r_base;
    logic                  r_hold;
    logic [LINE_W-1:0]     r_asm;
    logic [LINE_W-1:0]     r_rdata;
    logic [LINE_W-1:0]     w_asm_next;
    logic                  w_load;
    logic                  w_inc;
    logic                  w_last;
    logic                  w_in_burst;
    logic [BEAT_W-1:0]     w_beat;
    logic [BEAT_W-1:0]     w_start;
    logic                  w_unused_addr;

    // Byte/word offset bits only matter for the critical-word start beat
    assign w_unused_addr = ^line_addr[ADDR_LSB-1:0];

`ifdef CRITICAL_WORD_FIRST_EN
    // Reads begin at the requested word; writes always begin at word 0
    assign w_start = line_write ? '0 : line_addr[ADDR_LSB-1:1];
`else
    assign w_start = '0;
`endif

    // r_hold masks requests in the IDLE cycle after RESP so the initiator can drop them
    assign w_load     = (r_state == BRS_IDLE) && !r_hold && (line_read || line_write);
    assign w_in_burst = (r_state == BRS_RD_BEAT) || (r_state == BRS_WR_BEAT);
    assign w_inc      = w_in_burst && word_resp;
    assign line_rdata = r_rdata;

    burst_beat_counter #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W)
    ) u_beat_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_load),
        .start   (w_start),
        .inc     (w_inc),
        .beat    (w_beat),
        .last    (w_last)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= BRS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: write wins over read; leave a beat state after the final beat
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BRS_IDLE: begin
                if (!r_hold) begin
                    if (line_write) begin
                        w_next_state = BRS_WR_BEAT;
                    end else if (line_read) begin
                        w_next_state = BRS_RD_BEAT;
                    end
                end
            end
            BRS_RD_BEAT,
            BRS_WR_BEAT: begin
                if (w_inc && w_last) begin
                    w_next_state = BRS_RESP;
                end
            end
            BRS_RESP: w_next_state = BRS_IDLE;
            default:  w_next_state = BRS_IDLE;
        endcase
    end

    // Output decode from registered state so strobes are glitch-free and rise a cycle after the request
    always_comb begin
        line_resp  = (r_state == BRS_RESP);
        word_read  = (r_state == BRS_RD_BEAT);
        word_write = (r_state == BRS_WR_BEAT);
        word_addr  = w_in_burst ? {r_base, w_beat, 1'b0} : 16'h0000;
        word_wdata = (r_state == BRS_WR_BEAT) ? line_wdata[w_beat*WORD_W +: WORD_W] : '0;
        word_wmask = (r_state == BRS_WR_BEAT) ? 2'b11 : 2'b00;
    end

    // Assembly buffer with the current read beat merged into its true slot
    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[w_beat*WORD_W +: WORD_W] = word_rdata;
    end

    // Burst datapath: line base, post-RESP hold, read assembly; line_rdata only updates when a read completes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base  <= '0;
            r_hold  <= 1'b0;
            r_asm   <= '0;
            r_rdata <= '0;
        end else begin
            r_hold <= (r_state == BRS_RESP);
            if (w_load) begin
                r_base <= line_addr[15:ADDR_LSB];
            end
            if (w_inc && (r_state == BRS_RD_BEAT)) begin
                r_asm <= w_asm_next;
                if (w_last) begin
                    r_rdata <= w_asm_next;
                end
            end
        end
    end

endmodule : line_burst_responder

`default_nettype wire
